// File: rtl/z80_bus_slave.sv
// Purpose: cycle-level Z80 bus target for testbenches. It decodes memory, I/O and
//          IM2 interrupt-acknowledge cycles, inserts wait states, serves reads,
//          captures writes into a RAM window and into an output port latch.
// Latency: wait_n is low for WAIT_CYC clocks, starting at the clock that decodes
//          the cycle. Read data and drive enable are registered on XFER entry.
// Backpressure: stretches each decoded access with wait_n. d_oe is gated
//          combinationally by the read strobes, so it releases the bus together with the CPU.
//
// Ports:
//   clk, rst_n               Z80 clock and asynchronous active-low reset
//   a, d_i, d_o, d_oe        address bus, data in, data out, data drive enable
//   mreq_n .. rfsh_n         CPU strobes, sampled on the rising edge of clk
//   wait_n, int_n            wait request and interrupt request to the CPU
//   irq_req                  bench pulse that requests an interrupt
//   io_out, io_in            OUT latch and IN value for IO_PORT
//   rom_wr_err               sticky flag set by a write to the read-only half
//
// Optional build macro Z80_SLV_ROM_EN: the lower half of the RAM window
// (a[MEM_AW-1]=0) becomes read-only. Writes there are dropped and set rom_wr_err.
// Without the macro the whole window is writable and rom_wr_err is tied to 0.
module z80_bus_slave #(
    parameter int          MEM_AW   = 10,
    parameter logic [15:0] MEM_BASE = 16'h8000,
    parameter logic [7:0]  IO_PORT  = 8'hFE,
    parameter int          WAIT_CYC = 2,
    parameter logic [7:0]  IM2_VEC  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [7:0]  d_i,
    output logic [7:0]  d_o,
    output logic        d_oe,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    output logic        wait_n,
    output logic        int_n,
    input  logic        irq_req,
    output logic [7:0]  io_out,
    input  logic [7:0]  io_in,
    output logic        rom_wr_err
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_END} state_t;
    typedef enum logic [1:0] {C_MEM, C_IO, C_INTA, C_NONE} cyc_t;

    state_t              state_q, state_n;
    cyc_t                cyc_q, cur_cyc, sel_cyc;
    logic [MEM_AW-1:0]   addr_q, cur_addr;
    logic [3:0]          cnt_q;
    logic                wait_q;
    logic                drv_q;
    logic                int_q;

    logic [7:0]          ram [2**MEM_AW];

    logic                sel_mem, sel_io, sel_inta, sel_any;
    logic                strb_act, rd_cond, wr_fire, inta_strb;
    logic [7:0]          rd_data;
    logic                ram_we, io_we, rom_blk;

    // Select terms. Refresh cycles never decode as memory.
    assign sel_mem  = ~mreq_n & rfsh_n & (a[15:MEM_AW] == MEM_BASE[15:MEM_AW]);
    assign sel_io   = ~iorq_n & m1_n & (a[7:0] == IO_PORT);
    assign sel_inta = ~iorq_n & ~m1_n;
    assign sel_any  = sel_mem | sel_io | sel_inta;
    assign inta_strb = ~iorq_n & ~m1_n;

    always_comb begin
        sel_cyc = C_NONE;
        if (sel_mem) begin
            sel_cyc = C_MEM;
        end else if (sel_io) begin
            sel_cyc = C_IO;
        end else if (sel_inta) begin
            sel_cyc = C_INTA;
        end
    end

    // In IDLE the cycle is not latched yet, so the live decode is used. This lets
    // a zero-wait configuration load read data on the same edge as the decode.
    assign cur_cyc  = (state_q == S_IDLE) ? sel_cyc : cyc_q;
    assign cur_addr = (state_q == S_IDLE) ? a[MEM_AW-1:0] : addr_q;

    // Strobe that keeps the current cycle alive.
    assign strb_act = (cur_cyc == C_MEM) ? ~mreq_n : ~iorq_n;
    assign rd_cond  = (cur_cyc == C_INTA) ? inta_strb : ~rd_n;

    always_comb begin
        rd_data = 8'h00;
        case (cur_cyc)
            C_MEM:   rd_data = ram[cur_addr];
            C_IO:    rd_data = io_in;
            C_INTA:  rd_data = IM2_VEC;
            default: rd_data = 8'h00;
        endcase
    end

    // A write happens only on the first sampled wr_n=0 in XFER. The FSM leaves
    // XFER on the same edge, so the write cannot repeat.
    assign wr_fire = (state_q == S_XFER) & strb_act & ~wr_n & (cyc_q != C_INTA);

`ifdef Z80_SLV_ROM_EN
    assign rom_blk = ~addr_q[MEM_AW-1];
`else
    assign rom_blk = 1'b0;
`endif

    assign ram_we = wr_fire & (cyc_q == C_MEM) & ~rom_blk;
    assign io_we  = wr_fire & (cyc_q == C_IO);

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: begin
                if (sel_any) begin
                    state_n = (WAIT_CYC > 0) ? S_WAIT : S_XFER;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_n = S_XFER;
                end
            end
            S_XFER: begin
                // A read ends when its strobe is sampled high. A write moves to
                // END and waits there for all strobes to go inactive.
                if (!strb_act) begin
                    state_n = S_IDLE;
                end else if (wr_fire) begin
                    state_n = S_END;
                end
            end
            S_END: begin
                if (mreq_n && iorq_n) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= C_NONE;
            addr_q  <= '0;
            cnt_q   <= 4'd0;
            wait_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            if (state_q == S_IDLE && sel_any) begin
                cyc_q  <= sel_cyc;
                addr_q <= a[MEM_AW-1:0];
                if (WAIT_CYC > 0) begin
                    cnt_q  <= WAIT_LD;
                    wait_q <= 1'b0;
                end
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
                // The counter hits zero on this edge, so the wait ends here.
                if (cnt_q <= 4'd1) begin
                    wait_q <= 1'b1;
                end
            end
        end
    end

    // Read data and drive flag are captured when XFER is entered or held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_q <= 1'b0;
            d_o   <= 8'h00;
        end else if (state_n == S_XFER) begin
            if (rd_cond) begin
                drv_q <= 1'b1;
                d_o   <= rd_data;
            end
        end else begin
            drv_q <= 1'b0;
        end
    end

    // The combinational gate drops the drive in the same delta that the CPU
    // releases its read strobe.
    assign d_oe = drv_q & (state_q == S_XFER) &
                  ((cyc_q == C_INTA) ? inta_strb : ~rd_n);

    // An irq_req pulse on the same edge as the INTA sample takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q <= 1'b1;
        end else if (irq_req) begin
            int_q <= 1'b0;
        end else if (state_q == S_IDLE && sel_cyc == C_INTA) begin
            int_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_out <= 8'h00;
        end else if (io_we) begin
            io_out <= d_i;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[addr_q] <= d_i;
        end
    end

`ifdef Z80_SLV_ROM_EN
    logic rom_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_err_q <= 1'b0;
        end else if (wr_fire && cyc_q == C_MEM && rom_blk) begin
            rom_err_q <= 1'b1;
        end
    end
    assign rom_wr_err = rom_err_q;
`else
    assign rom_wr_err = 1'b0;
`endif

    assign wait_n = wait_q;
    assign int_n  = int_q;

endmodule

// File: tb/tb_z80_bus_slave.sv
module tb_z80_bus_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [7:0]  d_i = 8'h00;
    logic [7:0]  d_o;
    logic        d_oe;
    logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic        m1_n = 1'b1, rfsh_n = 1'b1;
    logic        wait_n, int_n;
    logic        irq_req = 1'b0;
    logic [7:0]  io_out;
    logic [7:0]  io_in = 8'h00;
    logic        rom_wr_err;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard queues: expected read bytes and expected wait_n-low lengths.
    logic [7:0] rd_q[$];
    int         wt_q[$];

    z80_bus_slave dut (
        .clk(clk), .rst_n(rst_n), .a(a), .d_i(d_i), .d_o(d_o), .d_oe(d_oe),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n), .wait_n(wait_n), .int_n(int_n),
        .irq_req(irq_req), .io_out(io_out), .io_in(io_in), .rom_wr_err(rom_wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT drives data or ends a wait.
    int  wcnt = 0;
    bit  doe_prev = 1'b0;
    always @(negedge clk) begin
        if (wait_n === 1'b0) begin
            wcnt++;
        end else if (wcnt > 0) begin
            if (wt_q.size() == 0) begin
                chk("unexpected_wait", 16'(wcnt), 16'd0);
            end else begin
                chk("wait_len", 16'(wcnt), 16'(wt_q.pop_front()));
            end
            wcnt = 0;
        end
        if (d_oe && !doe_prev) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_drive", {8'h00, d_o}, 16'hFFFF);
            end else begin
                chk("rd_data", {8'h00, d_o}, {8'h00, rd_q.pop_front()});
            end
        end
        doe_prev = d_oe;
    end

    // One CPU bus cycle. It holds the strobes until wait_n is sampled high,
    // then completes the data phase.
    task automatic bus_cycle(input logic [15:0] addr, input bit is_io, input bit is_wr,
                             input logic [7:0] wdat, output bit saw_wait);
        bit done;
        @(posedge clk); #1;
        a = addr;
        if (is_io) iorq_n = 1'b0; else mreq_n = 1'b0;
        if (is_wr) d_i = wdat; else rd_n = 1'b0;
        saw_wait = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(posedge clk); #1;
            if (!wait_n) saw_wait = 1'b1; else done = 1'b1;
        end
        chk("wait_release", {15'd0, done}, 16'd1);
        if (is_wr) begin
            wr_n = 1'b0;
            @(posedge clk); #1;
            wr_n = 1'b1;
        end else begin
            @(posedge clk); #1;
            rd_n = 1'b1;
            #1 chk("doe_drop_with_rd", {15'd0, d_oe}, 16'd0);
        end
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic inta_cycle(input bit coinc);
        bit done;
        @(posedge clk); #1;
        m1_n = 1'b0;
        @(posedge clk); #1;
        iorq_n = 1'b0;
        irq_req = coinc;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(posedge clk); #1;
            irq_req = 1'b0;
            if (wait_n) done = 1'b1;
        end
        chk("inta_wait_release", {15'd0, done}, 16'd1);
        @(posedge clk); #1;
        iorq_n = 1'b1;
        m1_n = 1'b1;
        @(posedge clk); #1;
    endtask

    bit sw;
    bit bad;

    initial begin
        #12;
        chk("rst_d_o", {8'h00, d_o}, 16'h0000);
        chk("rst_d_oe", {15'd0, d_oe}, 16'd0);
        chk("rst_wait_n", {15'd0, wait_n}, 16'd1);
        chk("rst_int_n", {15'd0, int_n}, 16'd1);
        chk("rst_io_out", {8'h00, io_out}, 16'h0000);
        chk("rst_rom_err", {15'd0, rom_wr_err}, 16'd0);
        rst_n = 1'b1;

        // Memory write followed by read-back, two wait clocks each.
        wt_q.push_back(2);
        bus_cycle(16'h8010, 1'b0, 1'b1, 8'h5A, sw);
        wt_q.push_back(2); rd_q.push_back(8'h5A);
        bus_cycle(16'h8010, 1'b0, 1'b0, 8'h00, sw);
        wt_q.push_back(2);
        bus_cycle(16'h83FF, 1'b0, 1'b1, 8'hA7, sw);
        wt_q.push_back(2); rd_q.push_back(8'hA7);
        bus_cycle(16'h83FF, 1'b0, 1'b0, 8'h00, sw);

        // I/O port.
        wt_q.push_back(2);
        bus_cycle(16'h00FE, 1'b1, 1'b1, 8'hC3, sw);
        chk("io_out_written", {8'h00, io_out}, 16'h00C3);
        io_in = 8'h3C;
        wt_q.push_back(2); rd_q.push_back(8'h3C);
        bus_cycle(16'h12FE, 1'b1, 1'b0, 8'h00, sw);
        bus_cycle(16'h00FD, 1'b1, 1'b1, 8'h99, sw);
        chk("io_fd_ignored", {8'h00, io_out}, 16'h00C3);
        chk("io_fd_no_wait", {15'd0, sw}, 16'd0);

        // Interrupt request and IM2 acknowledge.
        @(posedge clk); #1 irq_req = 1'b1;
        @(posedge clk); #1 irq_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("int_n_asserted", {15'd0, int_n}, 16'd0);
        wt_q.push_back(2); rd_q.push_back(8'hFF);
        inta_cycle(1'b0);
        chk("int_n_after_inta", {15'd0, int_n}, 16'd1);
        @(posedge clk); #1 irq_req = 1'b1;
        @(posedge clk); #1 irq_req = 1'b0;
        wt_q.push_back(2); rd_q.push_back(8'hFF);
        inta_cycle(1'b1);
        chk("int_n_coincident", {15'd0, int_n}, 16'd0);
        wt_q.push_back(2); rd_q.push_back(8'hFF);
        inta_cycle(1'b0);
        chk("int_n_cleared", {15'd0, int_n}, 16'd1);

        // Out-of-window access and refresh cycle are ignored.
        bus_cycle(16'h4000, 1'b0, 1'b0, 8'h00, sw);
        chk("miss_no_wait", {15'd0, sw}, 16'd0);
        @(posedge clk); #1;
        a = 16'h8010; mreq_n = 1'b0; rfsh_n = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (!wait_n || d_oe) bad = 1'b1;
        end
        mreq_n = 1'b1; rfsh_n = 1'b1;
        chk("rfsh_ignored", {15'd0, bad}, 16'd0);
        @(posedge clk); #1;

        // Reset during the wait phase of a read.
        wt_q.push_back(1);
        @(posedge clk); #1;
        a = 16'h8010; mreq_n = 1'b0; rd_n = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wait_n", {15'd0, wait_n}, 16'd1);
        chk("rst_mid_d_oe", {15'd0, d_oe}, 16'd0);
        mreq_n = 1'b1; rd_n = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        wt_q.push_back(2); rd_q.push_back(8'h5A);
        bus_cycle(16'h8010, 1'b0, 1'b0, 8'h00, sw);

`ifdef Z80_SLV_ROM_EN
        wt_q.push_back(2);
        bus_cycle(16'h8005, 1'b0, 1'b1, 8'h11, sw);
        chk("rom_err_set", {15'd0, rom_wr_err}, 16'd1);
        wt_q.push_back(2);
        bus_cycle(16'h8205, 1'b0, 1'b1, 8'h22, sw);
        wt_q.push_back(2); rd_q.push_back(8'h22);
        bus_cycle(16'h8205, 1'b0, 1'b0, 8'h00, sw);
        chk("rom_err_sticky", {15'd0, rom_wr_err}, 16'd1);
`else
        wt_q.push_back(2);
        bus_cycle(16'h8005, 1'b0, 1'b1, 8'h11, sw);
        wt_q.push_back(2); rd_q.push_back(8'h11);
        bus_cycle(16'h8005, 1'b0, 1'b0, 8'h00, sw);
        chk("rom_err_clear", {15'd0, rom_wr_err}, 16'd0);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("rd_q_drained", 16'(rd_q.size()), 16'd0);
        chk("wt_q_drained", 16'(wt_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
